// File: rtl/count_step_ctrl_if.sv
// Board-side and next-state-side signals of the mod-6 counter front end.
interface count_step_ctrl_if;
  logic       sw_updown;
  logic       btn_pause;
  logic [2:0] ns;
  logic [2:0] q;
  logic       up_down;
  logic       tick;
  logic       paused;

  modport master (output sw_updown, btn_pause, ns,
                  input  q, up_down, tick, paused);
  modport slave  (input  sw_updown, btn_pause, ns,
                  output q, up_down, tick, paused);
endinterface

// File: rtl/count_step_ctrl.sv
// Count register, step prescaler, pause FSM and input conditioning for the
// mod-6 up/down LED counter.
module count_step_db #(
  parameter int DB_CYCLES = 1_000_000,
  parameter bit RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= {2{RST_VAL}};
      level <= RST_VAL;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module count_step_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input logic              clk,
  input logic              rst_n,
  count_step_ctrl_if.slave bus
);
  localparam int NUM_IN = 2;
  // Lane 0 = direction switch (rests at up), lane 1 = pause button.
  localparam logic [NUM_IN-1:0] RST_VEC = 2'b01;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic {RUN, PAUSED} state_t;

  logic [NUM_IN-1:0] raw, lvl;
  state_t            state, state_nx;
  logic [PW-1:0]     pre, pre_nx;
  logic [2:0]        q_r;
  logic              btn_d, rise, tick;

  assign raw = {bus.btn_pause, bus.sw_updown};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    count_step_db #(.DB_CYCLES(DB_CYCLES), .RST_VAL(RST_VEC[i])) u_db (
      .clk(clk), .rst_n(rst_n), .raw(raw[i]), .level(lvl[i])
    );
  end

  assign rise = lvl[1] & ~btn_d;
  assign tick = (pre == PMAX) && (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pre   <= '0;
      btn_d <= 1'b0;
      q_r   <= 3'd0;
    end else begin
      state <= state_nx;
      pre   <= pre_nx;
      btn_d <= lvl[1];
      if (tick) q_r <= (bus.ns > 3'd5) ? 3'd0 : bus.ns;
    end
  end

  // Prescaler is parked at 0 while paused and on the edge that enters pause,
  // so a resume always waits a full period before the first tick.
  always_comb begin
    state_nx = state;
    pre_nx   = (pre == PMAX) ? '0 : pre + PW'(1);
    if (rise) state_nx = (state == RUN) ? PAUSED : RUN;
    if (state == PAUSED || rise) pre_nx = '0;
  end

  assign bus.q       = q_r;
  assign bus.up_down = lvl[0];
  assign bus.tick    = tick;
  assign bus.paused  = (state == PAUSED);
endmodule

// File: tb/tb_count_step_ctrl.sv
// Randomized bench for count_step_ctrl against a cycle-count reference model.
module tb_count_step_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  count_step_ctrl_if bus();
  count_step_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit force_en = 1'b0;
  logic [2:0] force_val = 3'd0;

  // Reference state: raw inputs seen at the last two edges, accepted levels
  // with their run of disagreeing samples, and cycles since the step phase
  // last restarted.
  bit m_sw_hist[2], m_btn_hist[2];
  bit m_ud, m_btn_acc, m_btn_prev, m_paused;
  int m_run_sw, m_run_btn, m_phase, m_q;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic db_model(input bit sample, inout bit acc, inout int run);
    if (sample == acc) run = 0;
    else begin
      run++;
      if (run == DB) begin acc = sample; run = 0; end
    end
  endtask

  function automatic bit m_tick();
    return !m_paused && (m_phase % TD == TD - 1);
  endfunction

  task automatic model_edge(input bit rst, input bit sw, input bit btn, input int ns);
    bit rise, np;
    if (!rst) begin
      m_sw_hist = '{1'b1, 1'b1}; m_btn_hist = '{1'b0, 1'b0};
      m_ud = 1; m_btn_acc = 0; m_btn_prev = 0; m_paused = 0;
      m_run_sw = 0; m_run_btn = 0; m_phase = 0; m_q = 0;
      return;
    end
    if (m_tick()) m_q = (ns > 5) ? 0 : ns;
    rise = m_btn_acc && !m_btn_prev;
    np = m_paused ^ rise;
    m_phase = (m_paused || np) ? 0 : m_phase + 1;
    m_paused = np;
    m_btn_prev = m_btn_acc;
    db_model(m_sw_hist[1], m_ud, m_run_sw);
    db_model(m_btn_hist[1], m_btn_acc, m_run_btn);
    m_sw_hist[1] = m_sw_hist[0]; m_sw_hist[0] = sw;
    m_btn_hist[1] = m_btn_hist[0]; m_btn_hist[0] = btn;
  endtask

  // One clock: the next-state logic (mod-6 counter) drives ns, model and DUT
  // advance across the edge, then all outputs are compared.
  task automatic step();
    int ns_v, qi;
    qi = int'(bus.q);
    if (force_en) ns_v = int'(force_val);
    else if (bus.up_down) ns_v = (qi >= 5) ? 0 : qi + 1;
    else ns_v = (qi == 0) ? 5 : qi - 1;
    bus.ns = 3'(ns_v);
    model_edge(rst_n, bus.sw_updown, bus.btn_pause, ns_v);
    @(posedge clk);
    #1;
    chk("q", 8'(bus.q), 8'(m_q));
    chk("up_down", 8'(bus.up_down), 8'(m_ud));
    chk("paused", 8'(bus.paused), 8'(m_paused));
    chk("tick", 8'(bus.tick), 8'(m_tick()));
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; bus.sw_updown = 1'b1; bus.btn_pause = 1'b0; bus.ns = 3'd0;
    steps(2);
    rst_n = 1'b1;
    // Run up through a full wrap.
    steps(30);
    // Bounce of two samples on the switch is rejected.
    bus.sw_updown = 1'b0; steps(2); bus.sw_updown = 1'b1; steps(8);
    // Held low: direction flips, counts down through 0->5.
    bus.sw_updown = 1'b0; steps(30);
    // Illegal next-state values across ticks.
    force_en = 1'b1; force_val = 3'd7; steps(5);
    force_val = 3'd6; steps(5);
    force_en = 1'b0; steps(4);
    // Pause with a long hold, release, idle, then resume.
    bus.btn_pause = 1'b1; steps(10);
    bus.btn_pause = 1'b0; steps(40);
    bus.btn_pause = 1'b1; steps(8);
    bus.btn_pause = 1'b0; steps(12);
    // Reset mid-operation while counting down and paused.
    guard = 0;
    while (m_q != 3 && guard < 40) begin step(); guard++; end
    bus.btn_pause = 1'b1; steps(7);
    bus.btn_pause = 1'b0; steps(3);
    rst_n = 1'b0; step();
    rst_n = 1'b1; bus.sw_updown = 1'b1; steps(12);
    // Collision: press so the accepted rise lands on a tick cycle.
    guard = 0;
    while (!(!m_paused && m_phase % TD == 2) && guard < 20) begin step(); guard++; end
    bus.btn_pause = 1'b1; steps(8);
    bus.btn_pause = 1'b0; steps(20);
    bus.btn_pause = 1'b1; steps(8);
    bus.btn_pause = 1'b0; steps(8);
    // Randomized inputs with occasional illegal ns and resets.
    repeat (150) begin
      int len;
      bus.sw_updown = 1'($urandom_range(0, 1));
      bus.btn_pause = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      repeat (len) begin
        force_en  = ($urandom_range(0, 9) == 0);
        force_val = 3'($urandom_range(6, 7));
        rst_n     = ($urandom_range(0, 199) != 0);
        step();
      end
    end
    rst_n = 1'b1; force_en = 1'b0; steps(4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
